// File: rtl/signed_seq_divider_if.sv
// Handshake and result bundle for the signed sequential divider.
interface signed_seq_divider_if;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic       overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/signed_seq_divider.sv
// 8-bit / 4-bit signed divider: restoring division on magnitudes, then sign fix.
// Fixed 10-cycle latency from accepted start to the done pulse.
module signed_seq_divider (
    input  logic                 clk,
    input  logic                 rst_n,
    signed_seq_divider_if.slave  dif
);
    localparam int unsigned DW = 8;
    localparam int unsigned VW = 4;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_q;
    logic [2:0]      cnt_q;
    logic [DW-1:0]   dvd_q;
    logic [VW-1:0]   dsr_q;
    logic [VW-1:0]   rem_q;
    logic [DW-1:0]   quo_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            dbz_q;
    logic            ovf_q;
    logic            busy_q;
    logic            done_q;
    logic [DW-1:0]   quotient_q;
    logic [VW-1:0]   remainder_q;
    logic            dbz_out_q;
    logic            ovf_out_q;

    logic [VW:0]     trial_c;
    logic [VW-1:0]   diff_c;
    logic            ge_c;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        trial_c = {rem_q, dvd_q[DW-1]};
        ge_c    = trial_c >= {1'b0, dsr_q};
        diff_c  = VW'(trial_c - {1'b0, dsr_q});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_out_q   <= 1'b0;
            ovf_out_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (dif.start) begin
                        dvd_q     <= dif.dividend[DW-1] ? DW'(-dif.dividend) : dif.dividend;
                        dsr_q     <= dif.divisor[VW-1]  ? VW'(-dif.divisor)  : dif.divisor;
                        neg_quo_q <= dif.dividend[DW-1] ^ dif.divisor[VW-1];
                        neg_rem_q <= dif.dividend[DW-1];
                        dbz_q     <= dif.divisor == '0;
                        ovf_q     <= (dif.dividend == 8'h80) && (dif.divisor == 4'hF);
                        rem_q     <= '0;
                        quo_q     <= '0;
                        cnt_q     <= 3'd7;
                        busy_q    <= 1'b1;
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    rem_q <= ge_c ? diff_c : trial_c[VW-1:0];
                    quo_q <= {quo_q[DW-2:0], ge_c};
                    dvd_q <= {dvd_q[DW-2:0], 1'b0};
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    // Results become visible here and hold until the next completion.
                    dbz_out_q <= dbz_q;
                    ovf_out_q <= ovf_q;
                    if (dbz_q) begin
                        quotient_q  <= '0;
                        remainder_q <= '0;
                    end else if (ovf_q) begin
                        quotient_q  <= 8'h7F;
                        remainder_q <= '0;
                    end else begin
                        quotient_q  <= neg_quo_q ? DW'(-quo_q) : quo_q;
                        remainder_q <= neg_rem_q ? VW'(-rem_q) : rem_q;
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dif.busy        = busy_q;
    assign dif.done        = done_q;
    assign dif.quotient    = quotient_q;
    assign dif.remainder   = remainder_q;
    assign dif.div_by_zero = dbz_out_q;
    assign dif.overflow    = ovf_out_q;
endmodule
